mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
Dot-product front end for the multi-cycle `multiplier`. It accepts a stream of signed operand pairs over a valid/ready handshake and issues one multiplier transaction per pair. It accumulates the signed products over TERMS pairs and emits the sum on a valid/ready output. The block sits directly upstream of the multiplier, driving its operands and start, and directly downstream of it, consuming its product and valid.

Parameters:
WIDTH, 10, operand MSB index; operands are WIDTH+1 bits signed, matching the multiplier.
TERMS, 8, products per dot product; legal range 2..256.
TIMEOUT, 16, maximum WAIT cycles before abort; used only with MAC_TIMEOUT_EN.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
in_a  in  WIDTH+1  signed operand A.
in_b  in  WIDTH+1  signed operand B.
in_valid  in  1  operand pair valid.
in_ready  out  1  sequencer can take a pair.
mul_a  out  WIDTH+1  operand A to the multiplier.
mul_b  out  WIDTH+1  operand B to the multiplier.
mul_start  out  1  one-cycle start pulse to the multiplier.
mul_c  in  2*WIDTH+2  signed product from the multiplier.
mul_valid  in  1  product valid from the multiplier.
out_sum  out  ACC_W  signed sum; ACC_W = 2*WIDTH+2+$clog2(TERMS).
out_valid  out  1  sum valid.
out_ready  in  1  consumer accepts the sum.
err  out  1  sticky timeout flag; tied to 0 without MAC_TIMEOUT_EN.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state FETCH, accumulator 0, term count 0, mul_a/mul_b 0, mul_start 0, out_sum 0, out_valid 0, err 0. in_ready is 1 in the cycle after reset deasserts.
- Reset asserted mid-operation abandons the partial sum. Any product that arrives later is ignored, because mul_valid is sampled only in WAIT.
- FETCH: in_ready=1. When in_valid=1, register in_a/in_b onto mul_a/mul_b and go to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle. mul_a/mul_b hold stable. Go to WAIT.
- WAIT:
  - mul_start=0.
  - On mul_valid=1, add sign-extend(mul_c) to the accumulator.
  - If count==TERMS-1, register the new sum into out_sum, clear count, and go to OUTPUT.
  - Otherwise increment count and go to FETCH.
- OUTPUT:
  - out_valid=1 and out_sum is held stable.
  - On out_ready=1, clear the accumulator, drop out_valid, and go to FETCH.
  - in_ready=0 throughout OUTPUT; there is no overlap between batches.
- Handshakes:
  - in_ready/out_valid are registered-state decodes.
  - A transfer occurs only when valid and ready are high in the same cycle.
  - Only FETCH can accept a pair, so at most one pair is in flight.
- Timing:
  - The multiplier asserts mul_valid 2 cycles after the ISSUE cycle.
  - Minimum cost per term is 4 cycles (FETCH, ISSUE, WAIT x2).
  - Minimum batch latency is 4*TERMS cycles from the first in transfer to out_valid.
- Arithmetic:
  - All values are two's complement.
  - ACC_W guarantees no overflow for TERMS products of the most negative operands.
  - No saturation and no rounding.
- mul_valid outside WAIT is ignored. Simultaneous in_valid during OUTPUT is not accepted; in_ready stays 0.

Optional Feature:
MAC_TIMEOUT_EN:
- Defined: a cycle counter runs in WAIT. If TIMEOUT cycles elapse without mul_valid, set err=1 (sticky until reset), clear the accumulator and count, and return to FETCH; no out_valid is produced for that batch.
- Undefined: no counter exists, WAIT holds indefinitely, and err is constant 0.

Decomposition:
- Package mac_pkg: state enum (FETCH, ISSUE, WAIT, OUTPUT), function acc_width(WIDTH, TERMS), and count width $clog2(TERMS).
- No sub-module. The multiplier is instantiated beside this block by the parent, not inside it.

Test Plan:
- WIDTH=10, TERMS=4, pairs (3,4),(-5,6),(7,-8),(-1,-1), paired with the real multiplier -> out_sum=-73; out_valid at cycle 16 after the first transfer.
- Four pairs of (-1024,-1024) -> out_sum=4194304 with no overflow; the sign bit of the 24-bit sum is 0.
- out_ready held low 5 cycles during OUTPUT -> out_sum/out_valid stable, in_ready=0, then one transfer and return to FETCH.
- in_valid gapped (1 every 7 cycles) -> mul_start pulses exactly once per pair; the sum is correct.
- Reset asserted in WAIT of the 3rd term, then the full batch (1,1)x4 -> out_sum=4; the stale product is ignored.
- MAC_TIMEOUT_EN, TIMEOUT=16, with a multiplier stub that never asserts valid -> err=1 after the 16th WAIT cycle, state FETCH, out_valid never asserted.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the dot-product sequencer.
package mac_pkg;

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    WAIT,
    OUTPUT
  } state_e;

  // Product width plus enough headroom to sum TERMS worst-case products.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned terms);
    return 2 * width + 2 + $clog2(terms);
  endfunction

  function automatic int unsigned count_width(input int unsigned terms);
    return $clog2(terms);
  endfunction

endpackage

// File: rtl/mac_sequencer.sv
// Dot-product front end for the multi-cycle multiplier: one multiply per operand pair, TERMS-long sums.
// Optional WAIT watchdog with sticky err when MAC_TIMEOUT_EN is defined.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter  int unsigned WIDTH   = 10,
  parameter  int unsigned TERMS   = 8,
  parameter  int unsigned TIMEOUT = 16,
  localparam int unsigned ACC_W   = acc_width(WIDTH, TERMS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [WIDTH:0]     in_a,
  input  logic signed [WIDTH:0]     in_b,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [WIDTH:0]     mul_a,
  output logic signed [WIDTH:0]     mul_b,
  output logic                      mul_start,
  input  logic signed [2*WIDTH+1:0] mul_c,
  input  logic                      mul_valid,
  output logic signed [ACC_W-1:0]   out_sum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err
);

  localparam int unsigned CNT_W  = count_width(TERMS);
  localparam int unsigned PROD_W = 2 * WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(TERMS - 1);

  if (TERMS < 2 || TERMS > 256 || TIMEOUT < 1) begin : g_bad_params
    $error("mac_sequencer: TERMS must be 2..256 and TIMEOUT at least 1");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic signed [WIDTH:0]   a_q, a_d;
  logic signed [WIDTH:0]   b_q, b_d;
  logic signed [ACC_W-1:0] acc_next;

  assign acc_next = acc_q + {{(ACC_W - PROD_W){mul_c[PROD_W-1]}}, mul_c};

`ifdef MAC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef MAC_TIMEOUT_EN
    tmo_d   = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      FETCH: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_valid) begin
          acc_d = acc_next;
          if (cnt_q == LAST_TERM) begin
            sum_d   = acc_next;
            cnt_d   = '0;
            state_d = OUTPUT;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = FETCH;
          end
        end
`ifdef MAC_TIMEOUT_EN
        // A stalled multiplier abandons the whole batch, not just this term.
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      OUTPUT: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef MAC_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef MAC_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == FETCH);
  assign mul_start = (state_q == ISSUE);
  assign out_valid = (state_q == OUTPUT);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign out_sum   = sum_q;
`ifdef MAC_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: 2-cycle multiplier stub, scoreboard of dot products, directed and random batches.
module tb_mac_sequencer;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned TERMS = 4;
  localparam int unsigned ACC_W = 2 * WIDTH + 2 + $clog2(TERMS);

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic signed [WIDTH:0]     in_a = '0;
  logic signed [WIDTH:0]     in_b = '0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic signed [WIDTH:0]     mul_a;
  logic signed [WIDTH:0]     mul_b;
  logic                      mul_start;
  logic signed [2*WIDTH+1:0] mul_c = '0;
  logic                      mul_valid = 1'b0;
  logic signed [ACC_W-1:0]   out_sum;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic                      err;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  mac_sequencer #(
    .WIDTH  (WIDTH),
    .TERMS  (TERMS),
    .TIMEOUT(16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_start(mul_start),
    .mul_c    (mul_c),
    .mul_valid(mul_valid),
    .out_sum  (out_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Multiplier stand-in: product valid two cycles after the start cycle.
  bit                        stub_dead = 1'b0;
  logic                      p1_v = 1'b0;
  logic signed [2*WIDTH+1:0] p1_c = '0;
  always @(posedge clock) begin
    p1_v      <= mul_start && !stub_dead;
    p1_c      <= mul_a * mul_b;
    mul_valid <= p1_v;
    mul_c     <= p1_c;
  end

  // Output consumer.
  bit sink_hold = 1'b0;
  bit sink_rand = 1'b0;
  always @(posedge clock) begin
    #1;
    out_ready = sink_hold ? 1'b0 : (sink_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Reference: every accepted pair adds a*b; every TERMS pairs yields one expected sum.
  longint m_sum = 0;
  int     m_cnt = 0;
  longint sb[$];
  int     n_xfer = 0;
  int     n_start = 0;
  always @(negedge clock) begin
    if (reset) begin
      m_sum = 0;
      m_cnt = 0;
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        m_sum += longint'(in_a) * longint'(in_b);
        m_cnt++;
        n_xfer++;
        if (m_cnt == TERMS) begin
          sb.push_back(m_sum);
          m_sum = 0;
          m_cnt = 0;
        end
      end
      if (mul_start) n_start++;
      if (out_valid && out_ready) begin
        check("sb_pending", longint'(sb.size() != 0), 1);
        if (sb.size() != 0) check("sum_model", out_sum, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pair(input longint a, input longint b, output int xc);
    bit done = 1'b0;
    xc = -1;
    in_a = (WIDTH + 1)'(a);
    in_b = (WIDTH + 1)'(b);
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      done = in_ready && !reset;
      xc = cyc;
      tick();
      if (done) break;
    end
    in_valid = 1'b0;
    check("send_accepted", longint'(done), 1);
  endtask

  task automatic wait_out(output int c);
    bit got = 1'b0;
    c = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (out_valid) begin
        got = 1'b1;
        c = cyc;
        break;
      end
    end
    check("out_valid_seen", longint'(got), 1);
  endtask

  function automatic longint rnd_op();
    return longint'($urandom_range(0, 2047)) - 1024;
  endfunction

  initial begin
    int     t0, tx, tout, s0;
    longint a, b, exp, held;
    longint da[4];
    longint db[4];

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_err", err, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    tick();

    // Small mixed-sign batch, back to back, with first-transfer-to-out_valid latency
    da = '{3, -5, 7, -1};
    db = '{4, 6, -8, -1};
    send_pair(da[0], db[0], t0);
    for (int i = 1; i < 4; i++) send_pair(da[i], db[i], tx);
    wait_out(tout);
    check("latency", longint'(tout - t0), 16);
    check("sum_mixed", out_sum, -73);

    // Most-negative operands: largest positive sum, no overflow
    for (int i = 0; i < 4; i++) send_pair(-1024, -1024, tx);
    wait_out(tout);
    check("sum_maxneg", out_sum, 4194304);
    check("sum_maxneg_msb", out_sum[ACC_W-1], 0);

    // Consumer stalls for 5 cycles in OUTPUT while a pair is offered
    sink_hold = 1'b1;
    for (int i = 0; i < 4; i++) send_pair(rnd_op(), rnd_op(), tx);
    wait_out(tout);
    held = out_sum;
    s0 = n_xfer;
    tick();
    in_a = 11'sd9;
    in_b = 11'sd9;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_sum", out_sum, held);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check("hold_no_accept", longint'(n_xfer - s0), 0);
    sink_hold = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!out_valid) break;
    end
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    tick();

    // Gapped input: one pair every 7 cycles
    s0 = n_start;
    exp = 0;
    for (int i = 0; i < 4; i++) begin
      a = rnd_op();
      b = rnd_op();
      exp += a * b;
      send_pair(a, b, tx);
      if (i < 3) repeat (6) tick();
    end
    wait_out(tout);
    check("start_per_pair", longint'(n_start - s0), 4);
    check("sum_gapped", out_sum, exp);
    tick();

    // Reset during WAIT of the third term; the stale product must not leak in
    send_pair(5, 5, tx);
    send_pair(5, 5, tx);
    send_pair(5, 5, tx);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(1, 1, tx);
    wait_out(tout);
    check("sum_after_reset", out_sum, 4);
    tick();

    // Random batches with random gaps and random consumer back-pressure
    sink_rand = 1'b1;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < int'(TERMS); i++) begin
        send_pair(rnd_op(), rnd_op(), tx);
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    check("sb_drained", longint'(sb.size()), 0);
    sink_rand = 1'b0;
    repeat (3) tick();

`ifdef MAC_TIMEOUT_EN
    // Multiplier never answers: abort after 16 WAIT cycles
    stub_dead = 1'b1;
    send_pair(2, 3, tx);
    repeat (16) tick();
    @(negedge clock);
    check("tmo_err_before", err, 0);
    check("tmo_in_ready_before", in_ready, 0);
    tick();
    @(negedge clock);
    check("tmo_err", err, 1);
    check("tmo_in_ready", in_ready, 1);
    check("tmo_out_valid", out_valid, 0);
    stub_dead = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clock);
    check("tmo_err_cleared", err, 0);
`else
    @(negedge clock);
    check("err_idle", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", err_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
